// File: rtl/start_pulse_gen_mc.sv
// start_pulse_gen_mc
// Multi-channel start pulse generator. Each channel watches a synchronous
// valid level, detects the selected edge type and turns each accepted edge
// into a fixed-width start pulse followed by an optional dead time. Each
// channel also keeps a count of accepted edges and a sticky flag for edges
// that were dropped because the channel was busy.
module start_pulse_gen_mc #(
    parameter int NUM_CH    = 4,
    parameter int PULSE_LEN = 1,
    parameter int HOLDOFF   = 0,
    parameter int CNT_W     = 16
) (
    input  logic                    fast_clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       valid_Ff,
    input  logic [1:0]              edge_mode,
    input  logic                    enable,
    input  logic                    clr_stats,
    output logic [NUM_CH-1:0]       start,
    output logic                    start_any,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       missed,
    output logic [NUM_CH*CNT_W-1:0] start_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Timer reload values. The timer counts down to zero, so a phase of
    // N cycles loads N-1. The HOLD reload is unused when HOLDOFF is 0.
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    state_t              state_q [NUM_CH];
    state_t              state_d [NUM_CH];
    logic [7:0]          tmr_q   [NUM_CH];
    logic [7:0]          tmr_d   [NUM_CH];
    logic [CNT_W-1:0]    cnt_q   [NUM_CH];

    logic [NUM_CH-1:0]   valid_d1;
    logic [NUM_CH-1:0]   rise;
    logic [NUM_CH-1:0]   fall;
    logic [NUM_CH-1:0]   edge_det;
    logic [NUM_CH-1:0]   accept;
    logic [NUM_CH-1:0]   miss_evt;
    logic [NUM_CH-1:0]   start_d;

    // Edge detection against the previous sample; the mode is applied
    // directly, so a mode change affects detection in the same cycle.
    always_comb begin
        rise = valid_Ff & ~valid_d1;
        fall = ~valid_Ff & valid_d1;
        case (edge_mode)
            2'b00:   edge_det = rise;
            2'b01:   edge_det = fall;
            2'b10:   edge_det = rise | fall;
            default: edge_det = '0;
        endcase
    end

    // Per-channel next-state logic: accept in IDLE, flag misses when busy.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every always_comb output gets a default before any branch,
            // so no path leaves it unassigned and no latch is inferred.
            state_d[i]  = state_q[i];
            tmr_d[i]    = tmr_q[i];
            accept[i]   = 1'b0;
            miss_evt[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (edge_det[i] && enable) begin
                        accept[i]  = 1'b1;
                        state_d[i] = PULSE;
                        tmr_d[i]   = PULSE_LOAD;
                    end
                end
                PULSE: begin
                    miss_evt[i] = edge_det[i] & enable;
                    if (tmr_q[i] == 8'd0) begin
                        if (HOLDOFF > 0) begin
                            state_d[i] = HOLD;
                            tmr_d[i]   = HOLD_LOAD;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end else begin
                        tmr_d[i] = tmr_q[i] - 8'd1;
                    end
                end
                HOLD: begin
                    miss_evt[i] = edge_det[i] & enable;
                    if (tmr_q[i] == 8'd0) begin
                        state_d[i] = IDLE;
                    end else begin
                        tmr_d[i] = tmr_q[i] - 8'd1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    tmr_d[i]   = 8'd0;
                end
            endcase
            start_d[i] = (state_d[i] == PULSE);
        end
    end

    // State, timers, edge history and registered pulse outputs.
    always_ff @(posedge fast_clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            valid_d1  <= '0;
            start     <= '0;
            start_any <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                tmr_q[i]   <= 8'd0;
            end
        end else begin
            valid_d1  <= valid_Ff;
            start     <= start_d;
            start_any <= |start_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                tmr_q[i]   <= tmr_d[i];
            end
        end
    end

    // Statistics: clear beats an accepted edge, a miss beats clear.
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            missed <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (miss_evt[i]) begin
                    missed[i] <= 1'b1;
                end else if (clr_stats) begin
                    missed[i] <= 1'b0;
                end
                if (clr_stats) begin
                    cnt_q[i] <= '0;
                end else if (accept[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Busy flags from the current state and packing of the counters.
    always_comb begin
        busy      = '0;
        start_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i]                     = (state_q[i] != IDLE);
            start_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule
